// File: rtl/blowfish_decrypt_core.sv
// Iterative Blowfish decryption core: one Feistel round per clock with the P-array walked downward.
// blowfish_sbox supplies the fixed S-box tables (s1..s4) shared with the encryption datapath.

module blowfish_sbox #(
    parameter int unsigned SEL = 0
) (
    input  logic [7:0]  idx_i,
    output logic [31:0] val_o
);
    // Table contents come from a fixed integer mixer, so every entry is a constant.
    function automatic logic [31:0] entry(input logic [31:0] sel, input logic [31:0] idx);
        logic [31:0] v;
        v = ((sel << 8) | idx) * 32'h9E37_79B1;
        v = v ^ (v >> 15);
        v = v * 32'h85EB_CA77;
        v = v ^ (v >> 13);
        v = v * 32'hC2B2_AE3D;
        v = v ^ (v >> 16);
        return v;
    endfunction

    logic [31:0] rom [256];

    for (genvar g = 0; g < 256; g++) begin : g_rom
        assign rom[g] = entry(SEL, g);
    end

    assign val_o = rom[idx_i];
endmodule

module blowfish_decrypt_core #(
    parameter int unsigned ROUNDS = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [32*(ROUNDS+2)-1:0]    p_array,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [63:0]                 in_block,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [63:0]                 out_block,
    output logic                        busy
);
    localparam int unsigned NP = ROUNDS + 2;
    localparam int unsigned CW = $clog2(NP);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   l_q, l_d;
    logic [31:0]   r_q, r_d;
    logic [63:0]   out_q, out_d;
    logic          valid_q, valid_d;

    logic [31:0]   p [NP];
    logic [31:0]   t;
    logic [31:0]   f;
    logic [31:0]   s1v, s2v, s3v, s4v;

    for (genvar g = 0; g < NP; g++) begin : g_p
        assign p[g] = p_array[32*g +: 32];
    end

    assign t = l_q ^ p[cnt_q];

    blowfish_sbox #(.SEL(0)) s1 (.idx_i(t[31:24]), .val_o(s1v));
    blowfish_sbox #(.SEL(1)) s2 (.idx_i(t[23:16]), .val_o(s2v));
    blowfish_sbox #(.SEL(2)) s3 (.idx_i(t[15:8]),  .val_o(s3v));
    blowfish_sbox #(.SEL(3)) s4 (.idx_i(t[7:0]),   .val_o(s4v));

    assign f = ((s1v + s2v) ^ s3v) + s4v;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            l_q     <= '0;
            r_q     <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            l_q     <= l_d;
            r_q     <= r_d;
            out_q   <= out_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        l_d     = l_q;
        r_d     = r_q;
        out_d   = out_q;
        valid_d = valid_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    l_d     = in_block[63:32];
                    r_d     = in_block[31:0];
                    cnt_d   = CW'(ROUNDS + 1);
                    state_d = RUN;
                end
            end
            RUN: begin
                if (cnt_q > CW'(2)) begin
                    l_d   = r_q ^ f;
                    r_d   = t;
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    // Last round skips the swap and folds in the P[0]/P[1] whitening.
                    out_d   = {t ^ p[0], (r_q ^ f) ^ p[1]};
                    valid_d = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = valid_q;
    assign out_block = out_q;
endmodule

// File: tb/tb_blowfish_decrypt_core.sv
// Randomized bench for blowfish_decrypt_core: blocks are encrypted by a behavioural Blowfish
// model and the core must return the original plaintext with the documented timing.

module tb_blowfish_decrypt_core;
    localparam int ROUNDS = 16;
    localparam int NP     = ROUNDS + 2;

    typedef logic [31:0] pArr_t [NP];

    logic              clk;
    logic              rst;
    logic [32*NP-1:0]  pArray;
    logic              inValid;
    logic              inReady;
    logic [63:0]       inBlock;
    logic              outValid;
    logic              outReady;
    logic [63:0]       outBlock;
    logic              busy;

    int checkCount;
    int passCount;

    blowfish_decrypt_core #(.ROUNDS(ROUNDS)) dut (
        .clk       (clk),
        .rst       (rst),
        .p_array   (pArray),
        .in_valid  (inValid),
        .in_ready  (inReady),
        .in_block  (inBlock),
        .out_valid (outValid),
        .out_ready (outReady),
        .out_block (outBlock),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the core wedges somewhere a bounded wait does not cover.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation still running, required to finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // S-box table i (0..3 for S1..S4) as defined for the encryption datapath.
    function automatic logic [31:0] sboxRef(input int sel, input logic [7:0] idx);
        logic [31:0] h;
        h = 32'(sel * 256 + int'(idx)) * 32'h9E37_79B1;
        h = h ^ (h >> 15);
        h = h * 32'h85EB_CA77;
        h = h ^ (h >> 13);
        h = h * 32'hC2B2_AE3D;
        h = h ^ (h >> 16);
        return h;
    endfunction

    function automatic logic [31:0] fRef(input logic [31:0] x);
        return ((sboxRef(0, x[31:24]) + sboxRef(1, x[23:16])) ^ sboxRef(2, x[15:8]))
               + sboxRef(3, x[7:0]);
    endfunction

    // Textbook Blowfish encryption; the core must invert it.
    function automatic logic [63:0] encryptRef(input pArr_t p, input logic [63:0] blk);
        logic [31:0] xl, xr, tmp;
        xl = blk[63:32];
        xr = blk[31:0];
        for (int i = 0; i < ROUNDS; i++) begin
            xl  = xl ^ p[i];
            xr  = xr ^ fRef(xl);
            tmp = xl;
            xl  = xr;
            xr  = tmp;
        end
        tmp = xl;
        xl  = xr;
        xr  = tmp;
        xr  = xr ^ p[ROUNDS];
        xl  = xl ^ p[ROUNDS + 1];
        return {xl, xr};
    endfunction

    function automatic void keySchedule(input logic [63:0] key, output pArr_t p);
        for (int k = 0; k < NP; k++) begin
            p[k] = (32'h243F_6A88 + 32'(k) * 32'h9E37_79B9) ^ ((k % 2 == 1) ? key[31:0] : key[63:32]);
        end
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checkCount++;
        if (got === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic loadKey(input pArr_t p);
        for (int k = 0; k < NP; k++) begin
            pArray[32*k +: 32] = p[k];
        end
    endtask

    task automatic waitIdle(input string tag);
        int w;
        w = 0;
        while (!inReady && w < 100) begin
            step();
            w++;
        end
        checkOutput({tag, " idle"}, {63'd0, inReady}, 64'd1);
    endtask

    // Decrypt one block under key p; optionally stall the consumer and poke in_valid meanwhile.
    task automatic applyStimulus(input string tag, input pArr_t p, input logic [63:0] pt, input int stall);
        logic [63:0] ct;
        int edges;
        ct = encryptRef(p, pt);
        loadKey(p);
        waitIdle(tag);
        inValid = 1'b1;
        inBlock = ct;
        step();
        inValid = 1'b0;
        edges = 0;
        while (!outValid && edges < 40) begin
            step();
            edges++;
        end
        checkOutput({tag, " latency"}, 64'(edges), 64'(ROUNDS));
        checkOutput({tag, " data"}, outBlock, pt);
        for (int s = 0; s < stall; s++) begin
            if (s == 3) begin
                inValid = 1'b1;
                inBlock = ~ct;
            end
            if (s == 5) inValid = 1'b0;
            step();
            checkOutput({tag, " stall data"}, outBlock, pt);
            checkOutput({tag, " stall flags"}, {61'd0, inReady, outValid, busy}, 64'b011);
        end
        inValid  = 1'b0;
        outReady = 1'b1;
        step();
        outReady = 1'b0;
        checkOutput({tag, " release"}, {61'd0, inReady, outValid, busy}, 64'b100);
    endtask

    task automatic resetMidRound();
        pArr_t p;
        logic [63:0] pt;
        logic sawValid;
        for (int k = 0; k < NP; k++) p[k] = $urandom;
        pt = {$urandom, $urandom};
        loadKey(p);
        waitIdle("midrst");
        inValid = 1'b1;
        inBlock = encryptRef(p, pt);
        step();
        inValid = 1'b0;
        repeat (6) step();
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midrst flags", {61'd0, inReady, outValid, busy}, 64'b100);
        checkOutput("midrst block", outBlock, 64'd0);
        step();
        step();
        rst = 1'b0;
        sawValid = 1'b0;
        repeat (30) begin
            step();
            sawValid = sawValid | outValid;
        end
        checkOutput("midrst no output", {63'd0, sawValid}, 64'd0);
        applyStimulus("post-rst", p, pt, 0);
    endtask

    // Back-to-back traffic with in_valid and out_ready held high: one block per ROUNDS+2 cycles.
    task automatic roundTrip(input int nBlocks);
        pArr_t p;
        logic [63:0] pt;
        int edges;
        outReady = 1'b1;
        waitIdle("rt");
        inValid = 1'b1;
        for (int n = 0; n < nBlocks; n++) begin
            for (int k = 0; k < NP; k++) p[k] = $urandom;
            pt = {$urandom, $urandom};
            loadKey(p);
            inBlock = encryptRef(p, pt);
            step();
            edges = 0;
            while (!outValid && edges < 40) begin
                step();
                edges++;
            end
            checkOutput("rt latency", 64'(edges), 64'(ROUNDS));
            checkOutput("rt data", outBlock, pt);
            step();
            checkOutput("rt ready", {62'd0, inReady, outValid}, 64'b10);
        end
        inValid  = 1'b0;
        outReady = 1'b0;
    endtask

    initial begin
        pArr_t p;
        checkCount = 0;
        passCount  = 0;
        rst      = 1'b1;
        inValid  = 1'b0;
        inBlock  = '0;
        outReady = 1'b0;
        pArray   = '0;

        #2;
        checkOutput("reset flags", {61'd0, inReady, outValid, busy}, 64'b100);
        checkOutput("reset block", outBlock, 64'd0);
        step();
        step();
        rst = 1'b0;

        keySchedule(64'h0, p);
        applyStimulus("zero-key", p, 64'h0, 0);
        keySchedule(64'hFFFF_FFFF_FFFF_FFFF, p);
        applyStimulus("ones-key", p, 64'hFFFF_FFFF_FFFF_FFFF, 0);

        for (int i = 0; i < 4; i++) begin
            keySchedule({$urandom, $urandom}, p);
            applyStimulus("random", p, {$urandom, $urandom}, 0);
        end

        keySchedule(64'h0123_4567_89AB_CDEF, p);
        applyStimulus("backpressure", p, 64'hDEAD_BEEF_0BAD_F00D, 10);

        resetMidRound();
        roundTrip(1000);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
